// File: rtl/ay_cmd_pkg.sv
// Shared AY-3-8910 bus command definitions for the BK-0011M parallel-port decoder.
// Command values double as the {BDIR,BC1} bus encoding.
package ay_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_INACT = 2'b00,
    CMD_RDPSG = 2'b01,
    CMD_WRPSG = 2'b10,
    CMD_LADDR = 2'b11
  } ay_cmd_e;

  localparam int MODE_ORIG  = 0;
  localparam int MODE_STAS1 = 1;

  typedef struct packed {
    logic inact;
    logic laddr;
    logic wrpsg;
    logic rdpsg;
  } ay_onehot_t;

  function automatic ay_onehot_t cmd_to_onehot(input ay_cmd_e cmd);
    ay_onehot_t oh;
    oh = 4'b0000;
    case (cmd)
      CMD_INACT: oh.inact = 1'b1;
      CMD_LADDR: oh.laddr = 1'b1;
      CMD_WRPSG: oh.wrpsg = 1'b1;
      CMD_RDPSG: oh.rdpsg = 1'b1;
      default:   oh.inact = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/bk_in_sync.sv
// Multi-bit flop-chain synchroniser; every stage resets to a caller-supplied
// inactive pattern so that reset never looks like an access.
module bk_in_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [STAGES];

  // Shift the asynchronous inputs through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_r[i] <= rst_val;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/bk_ay_cmd_decoder.sv
// BK-0011M XT5 port to AY-3-8910 command decoder.
// MODE selects the wiring: 0 = Novo/original, 1 = Stas1 (LADDR/WRPSG qualifier swapped).
// SYNC_STAGES is the synchroniser depth (2..3).
// Optional macro AY_CMD_GLITCH_FILTER_EN: a decoded command must be seen on two
// consecutive synchronised samples before it is accepted (one extra cycle latency).
module bk_ay_cmd_decoder
  import ay_cmd_pkg::*;
#(
  parameter int MODE        = MODE_ORIG,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       iwrbt,
  input  logic       dout,
  input  logic       isel2,
  input  logic [7:0] din,
  input  logic [7:0] ay_da_in,
  output logic       ay_inact,
  output logic       ay_laddr,
  output logic       ay_wrpsg,
  output logic       ay_rdpsg,
  output logic       ay_bdir,
  output logic       ay_bc1,
  output logic [7:0] ay_da_out,
  output logic       ay_da_oe,
  output logic [7:0] rdata,
  output logic       rdata_valid
);

  // Stas1 wiring inverts the meaning of the byte-write qualifier.
  localparam logic SWAP_WRBT = (MODE == MODE_STAS1) ? 1'b1 : 1'b0;
  // Inactive port levels: strobe low, nWRTBT high, read direction, nSEL2 high.
  localparam logic [11:0] SYNC_RST_VAL = {1'b0, 1'b1, 1'b0, 1'b1, 8'h00};

  logic [11:0] sync_in_s;
  logic [11:0] sync_out_s;
  logic        strobe_sync_s;
  logic        iwrbt_sync_s;
  logic        dout_sync_s;
  logic        isel2_sync_s;
  logic [7:0]  din_sync_s;

  ay_cmd_e     dec_cmd_s;
  ay_cmd_e     req_cmd_s;
  ay_cmd_e     cmd_nxt_s;
  ay_cmd_e     cmd_r;
  ay_onehot_t  oh_nxt_s;
  ay_onehot_t  oh_r;
  logic        drive_nxt_s;
  logic        rd_done_s;
  logic [1:0]  bus_ctl_r;
  logic        da_oe_r;
  logic [7:0]  da_out_r;
  logic [7:0]  rdata_r;
  logic        rdata_valid_r;

  assign sync_in_s = {strobe, iwrbt, dout, isel2, din};

  bk_in_sync #(
    .WIDTH  (12),
    .STAGES (SYNC_STAGES)
  ) u_in_sync (
    .clk     (clk),
    .rst     (rst),
    .rst_val (SYNC_RST_VAL),
    .d       (sync_in_s),
    .q       (sync_out_s)
  );

  assign {strobe_sync_s, iwrbt_sync_s, dout_sync_s, isel2_sync_s, din_sync_s} = sync_out_s;

  // Decode the synchronised port lines into the requested AY command.
  always_comb begin
    dec_cmd_s = CMD_INACT;
    if (strobe_sync_s && !isel2_sync_s) begin
      if (!dout_sync_s) begin
        dec_cmd_s = CMD_RDPSG;
      end else if (iwrbt_sync_s ^ SWAP_WRBT) begin
        dec_cmd_s = CMD_WRPSG;
      end else begin
        dec_cmd_s = CMD_LADDR;
      end
    end else begin
      dec_cmd_s = CMD_INACT;
    end
  end

`ifdef AY_CMD_GLITCH_FILTER_EN
  ay_cmd_e prev_dec_r;

  // Remember the previous decoded sample for the stability check.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_dec_r <= CMD_INACT;
    end else begin
      prev_dec_r <= dec_cmd_s;
    end
  end

  // Accept a new command only once two consecutive samples agree; otherwise hold.
  always_comb begin
    req_cmd_s = cmd_r;
    if (dec_cmd_s == prev_dec_r) begin
      req_cmd_s = dec_cmd_s;
    end else begin
      req_cmd_s = cmd_r;
    end
  end
`else
  // Every synchronised sample is taken as the request.
  always_comb begin
    req_cmd_s = dec_cmd_s;
  end
`endif

  // Next command: force one INACT cycle between two different active commands.
  always_comb begin
    cmd_nxt_s = req_cmd_s;
    if ((cmd_r != CMD_INACT) && (req_cmd_s != CMD_INACT) && (req_cmd_s != cmd_r)) begin
      cmd_nxt_s = CMD_INACT;
    end else begin
      cmd_nxt_s = req_cmd_s;
    end
  end

  // Next-cycle output values derived from the next command.
  always_comb begin
    oh_nxt_s    = cmd_to_onehot(cmd_nxt_s);
    drive_nxt_s = (cmd_nxt_s == CMD_LADDR) || (cmd_nxt_s == CMD_WRPSG);
    rd_done_s   = (cmd_r == CMD_RDPSG) && (cmd_nxt_s != CMD_RDPSG);
  end

  // Command state and registered command/bus-control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_r     <= CMD_INACT;
      oh_r      <= cmd_to_onehot(CMD_INACT);
      bus_ctl_r <= 2'b00;
    end else begin
      cmd_r     <= cmd_nxt_s;
      oh_r      <= oh_nxt_s;
      bus_ctl_r <= cmd_nxt_s;
    end
  end

  // Data path: drive AY bus on address/write, capture read data when a read ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      da_oe_r       <= 1'b0;
      da_out_r      <= 8'h00;
      rdata_r       <= 8'h00;
      rdata_valid_r <= 1'b0;
    end else begin
      da_oe_r       <= drive_nxt_s;
      rdata_valid_r <= rd_done_s;
      if (drive_nxt_s) begin
        da_out_r <= din_sync_s;
      end
      if (rd_done_s) begin
        rdata_r <= ay_da_in;
      end
    end
  end

  assign ay_inact    = oh_r.inact;
  assign ay_laddr    = oh_r.laddr;
  assign ay_wrpsg    = oh_r.wrpsg;
  assign ay_rdpsg    = oh_r.rdpsg;
  assign ay_bdir     = bus_ctl_r[1];
  assign ay_bc1      = bus_ctl_r[0];
  assign ay_da_out   = da_out_r;
  assign ay_da_oe    = da_oe_r;
  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;

endmodule

// File: tb/tb_bk_ay_cmd_decoder.sv
// Scoreboard bench: two decoder instances (Novo and Stas1 wiring) share the
// same port stimulus; every output change is matched against a queued
// expectation carrying the cycle on which it must appear.
module tb_bk_ay_cmd_decoder;

  localparam logic [1:0] C_IN = 2'd0;
  localparam logic [1:0] C_RD = 2'd1;
  localparam logic [1:0] C_WR = 2'd2;
  localparam logic [1:0] C_LA = 2'd3;

  typedef struct packed {
    logic [3:0] oh;   // {inact, laddr, wrpsg, rdpsg}
    logic [1:0] bb;   // {bdir, bc1}
    logic       oe;
    logic [7:0] da;
    logic [7:0] rd;
    logic       rv;
  } obs_t;

  typedef struct packed {
    int   cyc;
    obs_t v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe, iwrbt, dout, isel2;
  logic [7:0] din, ay_da_in;

  logic       m0_inact, m0_laddr, m0_wrpsg, m0_rdpsg, m0_bdir, m0_bc1, m0_oe, m0_rv;
  logic [7:0] m0_da, m0_rd;
  logic       m1_inact, m1_laddr, m1_wrpsg, m1_rdpsg, m1_bdir, m1_bc1, m1_oe, m1_rv;
  logic [7:0] m1_da, m1_rd;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q0[$];
  exp_t q1[$];
  obs_t now0, now1;
  obs_t prev0 = 'x;
  obs_t prev1 = 'x;

  always #5 clk = ~clk;

  bk_ay_cmd_decoder #(.MODE(0), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst(rst), .strobe(strobe), .iwrbt(iwrbt), .dout(dout), .isel2(isel2),
    .din(din), .ay_da_in(ay_da_in),
    .ay_inact(m0_inact), .ay_laddr(m0_laddr), .ay_wrpsg(m0_wrpsg), .ay_rdpsg(m0_rdpsg),
    .ay_bdir(m0_bdir), .ay_bc1(m0_bc1), .ay_da_out(m0_da), .ay_da_oe(m0_oe),
    .rdata(m0_rd), .rdata_valid(m0_rv)
  );

  bk_ay_cmd_decoder #(.MODE(1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .strobe(strobe), .iwrbt(iwrbt), .dout(dout), .isel2(isel2),
    .din(din), .ay_da_in(ay_da_in),
    .ay_inact(m1_inact), .ay_laddr(m1_laddr), .ay_wrpsg(m1_wrpsg), .ay_rdpsg(m1_rdpsg),
    .ay_bdir(m1_bdir), .ay_bc1(m1_bc1), .ay_da_out(m1_da), .ay_da_oe(m1_oe),
    .rdata(m1_rd), .rdata_valid(m1_rv)
  );

  assign now0 = {m0_inact, m0_laddr, m0_wrpsg, m0_rdpsg, m0_bdir, m0_bc1, m0_oe, m0_da, m0_rd, m0_rv};
  assign now1 = {m1_inact, m1_laddr, m1_wrpsg, m1_rdpsg, m1_bdir, m1_bc1, m1_oe, m1_da, m1_rd, m1_rv};

  // Cycle counter: increments on every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t mk(input logic [1:0] c, input logic [7:0] da,
                              input logic [7:0] rd, input logic rv);
    obs_t o;
    o.da = da;
    o.rd = rd;
    o.rv = rv;
    case (c)
      C_IN:    begin o.oh = 4'b1000; o.bb = 2'b00; o.oe = 1'b0; end
      C_LA:    begin o.oh = 4'b0100; o.bb = 2'b11; o.oe = 1'b1; end
      C_WR:    begin o.oh = 4'b0010; o.bb = 2'b10; o.oe = 1'b1; end
      default: begin o.oh = 4'b0001; o.bb = 2'b01; o.oe = 1'b0; end
    endcase
    return o;
  endfunction

  task automatic push(input int c, input logic [1:0] c0, input logic [1:0] c1,
                      input logic [7:0] da, input logic [7:0] rd, input logic rv);
    exp_t e;
    e.cyc = c;
    e.v   = mk(c0, da, rd, rv);
    q0.push_back(e);
    e.v   = mk(c1, da, rd, rv);
    q1.push_back(e);
  endtask

  task automatic to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon(input int k, input obs_t now, input obs_t prev);
    exp_t e;
    logic has;
    n_checks++;
    if ($onehot(now.oh)) n_pass++;
    else $display("FAIL onehot dut%0d cyc=%0d got=%b want one-hot", k, cyc, now.oh);
    has = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    e   = (k == 0) ? (has ? q0[0] : '0) : (has ? q1[0] : '0);
    if (has && e.cyc < cyc) begin
      n_checks++;
      $display("FAIL missed_change dut%0d cyc=%0d got=%h want=%h at cyc %0d", k, cyc, now, e.v, e.cyc);
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end else if (now !== prev) begin
      n_checks++;
      if (!has) begin
        $display("FAIL unexpected_change dut%0d cyc=%0d got=%h want=%h", k, cyc, now, prev);
      end else begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        if (e.cyc == cyc && e.v === now) n_pass++;
        else $display("FAIL output dut%0d cyc=%0d got=%h want=%h at cyc %0d", k, cyc, now, e.v, e.cyc);
      end
    end
  endtask

  // Monitor: sample both instances on the falling edge and check against the scoreboard.
  always @(negedge clk) begin
    mon(0, now0, prev0);
    mon(1, now1, prev1);
    prev0 <= now0;
    prev1 <= now1;
  end

  // Directed stimulus; expectations pushed as each access is issued.
  initial begin
    rst = 1'b1; strobe = 1'b1; dout = 1'b1; iwrbt = 1'b0; isel2 = 1'b0;
    din = 8'h32; ay_da_in = 8'h00;
    push(1, C_IN, C_IN, 8'h00, 8'h00, 1'b0);            // reset state with strobe high
    to(3);  rst = 1'b0;
    push(6, C_LA, C_WR, 8'h32, 8'h00, 1'b0);            // first command after reset
    to(8);  iwrbt = 1'b1;                               // back-to-back switch
    push(11, C_IN, C_IN, 8'h32, 8'h00, 1'b0);
    push(12, C_WR, C_LA, 8'h32, 8'h00, 1'b0);
    to(14); din = 8'h5A;                                // data follows while writing
    push(17, C_WR, C_LA, 8'h5A, 8'h00, 1'b0);
    to(20); isel2 = 1'b1;                               // deselected port
    push(23, C_IN, C_IN, 8'h5A, 8'h00, 1'b0);
    to(26); isel2 = 1'b0; dout = 1'b0; ay_da_in = 8'hCD; din = 8'h11;
    push(29, C_RD, C_RD, 8'h5A, 8'h00, 1'b0);
    to(32); strobe = 1'b0;                              // read ends
    push(35, C_IN, C_IN, 8'h5A, 8'hCD, 1'b1);
    push(36, C_IN, C_IN, 8'h5A, 8'hCD, 1'b0);
    to(37); ay_da_in = 8'h77;
    to(40); strobe = 1'b1;
    push(43, C_RD, C_RD, 8'h5A, 8'hCD, 1'b0);
    to(46); dout = 1'b1; iwrbt = 1'b1; din = 8'hA5;     // read straight to write
    push(49, C_IN, C_IN, 8'h5A, 8'h77, 1'b1);
    push(50, C_WR, C_LA, 8'hA5, 8'h77, 1'b0);
    to(53); rst = 1'b1;                                 // reset mid-command
    push(54, C_IN, C_IN, 8'h00, 8'h00, 1'b0);
    to(56); rst = 1'b0;
    push(59, C_WR, C_LA, 8'hA5, 8'h00, 1'b0);
    to(62); strobe = 1'b0;
    push(65, C_IN, C_IN, 8'hA5, 8'h00, 1'b0);
    to(68); strobe = 1'b1; din = 8'h3C;                 // one-cycle strobe pulse
    to(69); strobe = 1'b0;
    push(71, C_WR, C_LA, 8'h3C, 8'h00, 1'b0);
    push(72, C_IN, C_IN, 8'h3C, 8'h00, 1'b0);
    to(80);
    n_checks++;
    if (q0.size() == 0) n_pass++;
    else $display("FAIL leftover dut0 got=%0d pending want=0", q0.size());
    n_checks++;
    if (q1.size() == 0) n_pass++;
    else $display("FAIL leftover dut1 got=%0d pending want=0", q1.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bk_ay_cmd_decoder.md
Name: bk_ay_cmd_decoder

Overview:
Clocked decoder between the BK-0011M parallel port (XT5) control lines and an AY-3-8910 PSG bus. Synchronises the asynchronous port strobes and decodes them into exactly one AY bus command per cycle: INACT, LADDR, WRPSG or RDPSG. Drives BDIR/BC1 and the AY data bus. Wiring scheme is selected at elaboration: Novo/original (MODE=0) or Stas1 (MODE=1).

Parameters:
MODE, 0, wiring scheme: 0 = Novo/original, 1 = Stas1
SYNC_STAGES, 2, synchroniser depth for port inputs (legal range 2..3)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock, synchronous, active-high
strobe  in  1  port access strobe, active-high, asynchronous
iwrbt  in  1  byte-write qualifier, active-low (nWRTBT)
dout  in  1  bus direction: 1 = CPU write cycle, 0 = read cycle
isel2  in  1  port select, active-low (nSEL2)
din  in  8  port output pins D7-D0 (CPU to AY)
ay_da_in  in  8  AY DA7-DA0 read back
ay_inact  out  1  command INACT
ay_laddr  out  1  command latch address
ay_wrpsg  out  1  command write PSG
ay_rdpsg  out  1  command read PSG
ay_bdir  out  1  AY BDIR
ay_bc1  out  1  AY BC1
ay_da_out  out  8  data driven to AY
ay_da_oe  out  1  AY data bus output enable
rdata  out  8  last value read from AY
rdata_valid  out  1  one-cycle pulse: rdata updated

Behaviour:
- strobe, iwrbt, dout, isel2, din pass through SYNC_STAGES flops; decode and output registers follow. Latency input change to command change = SYNC_STAGES+1 cycles (3 at default).
- Active access A = strobe & ~isel2. A=0 -> INACT.
- MODE=0: A & dout & ~iwrbt -> LADDR; A & dout & iwrbt -> WRPSG; A & ~dout -> RDPSG.
- MODE=1: A & dout & iwrbt -> LADDR; A & dout & ~iwrbt -> WRPSG; A & ~dout -> RDPSG.
- Four command outputs strictly one-hot every cycle, including reset.
- Encoding (BDIR,BC1): INACT 00, RDPSG 01, WRPSG 10, LADDR 11.
- Direct switch between two non-INACT commands is forbidden: exactly one INACT cycle is inserted, then the new command.
- ay_da_out = registered synchronised din, updated only while next command is LADDR or WRPSG; held otherwise. ay_da_oe = 1 during LADDR/WRPSG, else 0.
- During RDPSG, ay_da_in is sampled on the last RDPSG cycle (command leaving RDPSG) into rdata; rdata_valid pulses 1 cycle.
- Reset (any time, including mid-command): ay_inact=1, other commands 0, bdir=bc1=0, ay_da_oe=0, ay_da_out=0, rdata=0, rdata_valid=0, synchroniser flops cleared to the inactive level (strobe=0, iwrbt=1, dout=0, isel2=1). The first command after reset needs the full latency.

Optional Feature:
AY_CMD_GLITCH_FILTER_EN: decoded command must be identical on 2 consecutive synchronised samples before it is registered. Latency becomes SYNC_STAGES+2, and single-cycle strobe pulses are ignored. Without the macro, every synchronised sample is decoded, so one-cycle pulses produce one-cycle commands.

Decomposition:
- Package ay_cmd_pkg: 2-bit command type {CMD_INACT=00, CMD_RDPSG=01, CMD_WRPSG=10, CMD_LADDR=11}, constants MODE_ORIG=0 and MODE_STAS1=1, and a function mapping command to one-hot outputs.
- One sub-module, bk_in_sync: parameterised multi-bit flop synchroniser with reset value input.

Test Plan:
- Reset: hold rst 3 cycles with strobe=1 -> ay_inact=1, bdir/bc1=00, da_oe=0, rdata=0.
- MODE=0, din=8'h32, strobe=1, dout=1, iwrbt=0, isel2=0 -> after 3 cycles LADDR=1, bdir/bc1=11, ay_da_out=8'h32. Same access with iwrbt=1 -> WRPSG, bdir/bc1=10.
- MODE=1, same two accesses -> command mapping swapped: iwrbt=0 gives WRPSG, iwrbt=1 gives LADDR.
- Read: strobe=1, dout=0, ay_da_in=8'hCD -> RDPSG (bdir/bc1=01), da_oe=0. After strobe drops, rdata=8'hCD and rdata_valid pulses once.
- Back-to-back: switch from LADDR to WRPSG without dropping strobe -> exactly one INACT cycle between them, and outputs stay one-hot throughout.
- isel2=1 with strobe=1 -> INACT only. Assert rst during WRPSG -> INACT on the next edge.
